// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: schedules FP result writebacks (load, fadd, fmul, fdiv) onto
// the two register-file write ports (y, x) with a round-robin arbiter and
// registered port outputs. It also holds a 32-entry pending-write scoreboard
// that the issue stage uses for RAW lookups and for stalling WAW.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_rd/req_data   per-source writeback request (source i at slice i)
//   req_ready                   per-source grant; transfer on valid&ready at posedge
//   wey/wny/dy, wex/wnx/dx      registered write ports (y is the high-priority port)
//   iss_valid/iss_rd/iss_ready  dispatch of an op that will write iss_rd
//   rs_a/rs_b -> busy_a/busy_b  combinational pending lookups
// Latency: grant edge -> port valid for one cycle -> regfile write at the next edge.
// Backpressure: ungranted sources hold their request; a dispatch to a pending
// register is held off by iss_ready=0 until its writeback has been written.
module fp_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_valid,
  input  logic [4*AW-1:0] req_rd,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      req_ready,
  output logic            wey,
  output logic [AW-1:0]   wny,
  output logic [DW-1:0]   dy,
  output logic            wex,
  output logic [AW-1:0]   wnx,
  output logic [DW-1:0]   dx,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   rs_a,
  input  logic [AW-1:0]   rs_b,
  output logic            busy_a,
  output logic            busy_b
);

  localparam int NREG = 1 << AW;

  logic [AW-1:0]   rd_arr  [4];
  logic [DW-1:0]   dat_arr [4];
  logic [1:0]      rr;
  logic            y_vld, x_vld;
  logic [1:0]      y_idx, x_idx, scan_idx;
  logic [NREG-1:0] pending, pending_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign rd_arr[i]  = req_rd[i*AW +: AW];
    assign dat_arr[i] = req_data[i*DW +: DW];
  end

  // Scan from rr upward. The first valid source takes slot y; the next valid
  // source with a different destination takes slot x, so both ports never
  // target the same register in one cycle.
  always_comb begin
    y_vld     = 1'b0;
    x_vld     = 1'b0;
    y_idx     = 2'd0;
    x_idx     = 2'd0;
    scan_idx  = 2'd0;
    req_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr + 2'(k);
      if (req_valid[scan_idx]) begin
        if (!y_vld) begin
          y_vld = 1'b1;
          y_idx = scan_idx;
        end else if (!x_vld && (rd_arr[scan_idx] != rd_arr[y_idx])) begin
          x_vld = 1'b1;
          x_idx = scan_idx;
        end
      end
    end
    if (y_vld) req_ready[y_idx] = 1'b1;
    if (x_vld) req_ready[x_idx] = 1'b1;
  end

  // Port registers. An empty slot only drops its write enable; the register
  // number and data keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr  <= 2'd0;
      wey <= 1'b0;
      wny <= '0;
      dy  <= '0;
      wex <= 1'b0;
      wnx <= '0;
      dx  <= '0;
    end else begin
      wey <= y_vld;
      wex <= x_vld;
      if (y_vld) begin
        wny <= rd_arr[y_idx];
        dy  <= dat_arr[y_idx];
      end
      if (x_vld) begin
        wnx <= rd_arr[x_idx];
        dx  <= dat_arr[x_idx];
      end
      // x is always later in scan order than y, so it is the last grant.
      if (x_vld)      rr <= x_idx + 2'd1;
      else if (y_vld) rr <= y_idx + 2'd1;
    end
  end

  // A register is pending from dispatch until the edge on which its value is
  // written. iss_ready looks at the current bit, so a register still being
  // cleared this cycle cannot be set again in the same cycle.
  assign iss_ready = ~pending[iss_rd];
  assign busy_a    = pending[rs_a];
  assign busy_b    = pending[rs_b];

  always_comb begin
    pending_nxt = pending;
    if (wey) pending_nxt[wny] = 1'b0;
    if (wex) pending_nxt[wnx] = 1'b0;
    if (iss_valid && iss_ready) pending_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Testbench for fp_wb_arbiter: directed scenarios followed by random traffic.
// The reference model predicts grants, port contents and the scoreboard from
// the arbitration rules; a separate monitor compares the registered ports.
module tb_fp_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic          wey;
    logic [AW-1:0] wny;
    logic [DW-1:0] dy;
    logic          wex;
    logic [AW-1:0] wnx;
    logic [DW-1:0] dx;
  } port_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [3:0]      req_ready;
  logic            wey, wex;
  logic [AW-1:0]   wny, wnx;
  logic [DW-1:0]   dy, dx;
  logic            iss_valid = 1'b0;
  logic [AW-1:0]   iss_rd = '0;
  logic            iss_ready;
  logic [AW-1:0]   rs_a = '0;
  logic [AW-1:0]   rs_b = '0;
  logic            busy_a, busy_b;

  // Source drivers
  logic            s_vld [4];
  logic [AW-1:0]   s_rd  [4];
  logic [DW-1:0]   s_dat [4];

  wire [3:0]      req_valid = {s_vld[3], s_vld[2], s_vld[1], s_vld[0]};
  wire [4*AW-1:0] req_rd    = {s_rd[3], s_rd[2], s_rd[1], s_rd[0]};
  wire [4*DW-1:0] req_data  = {s_dat[3], s_dat[2], s_dat[1], s_dat[0]};

  fp_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .wey(wey), .wny(wny), .dy(dy), .wex(wex), .wnx(wnx), .dx(dx),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs_a(rs_a), .rs_b(rs_b), .busy_a(busy_a), .busy_b(busy_b)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int    m_rr;
  bit    m_pend [32];
  port_t cur;
  bit    g [4];
  bit    iss_acc;
  port_t exp_q [$];

  // Evaluated mid-cycle: checks combinational outputs, then advances the model
  // across the coming rising edge and queues the expected port contents.
  task automatic model_step();
    int y, x, s;
    logic [3:0] er;
    chk("iss_ready", 64'(iss_ready), 64'(!m_pend[iss_rd]));
    chk("busy_a", 64'(busy_a), 64'(m_pend[rs_a]));
    chk("busy_b", 64'(busy_b), 64'(m_pend[rs_b]));
    y = -1;
    x = -1;
    for (int k = 0; k < 4; k++) begin
      s = (m_rr + k) % 4;
      if (s_vld[s]) begin
        if (y < 0) y = s;
        else if (x < 0 && s_rd[s] != s_rd[y]) x = s;
      end
    end
    er = 4'b0000;
    if (y >= 0) er[y] = 1'b1;
    if (x >= 0) er[x] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    iss_acc = iss_valid && !m_pend[iss_rd];
    if (cur.wey) m_pend[cur.wny] = 1'b0;
    if (cur.wex) m_pend[cur.wnx] = 1'b0;
    if (iss_acc) m_pend[iss_rd] = 1'b1;
    cur.wey = (y >= 0);
    if (y >= 0) begin
      cur.wny = s_rd[y];
      cur.dy  = s_dat[y];
    end
    cur.wex = (x >= 0);
    if (x >= 0) begin
      cur.wnx = s_rd[x];
      cur.dx  = s_dat[x];
    end
    exp_q.push_back(cur);
    if (x >= 0)      m_rr = (x + 1) % 4;
    else if (y >= 0) m_rr = (y + 1) % 4;
    for (int i = 0; i < 4; i++) g[i] = (i == y) || (i == x);
  endtask

  // Called at posedge+1; returns at the next posedge+1 with granted sources
  // and an accepted dispatch retired.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (g[i]) s_vld[i] = 1'b0;
    if (iss_acc) iss_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_wey", 64'(wey), 64'd0);
    chk("rst_wex", 64'(wex), 64'd0);
    chk("rst_wny_wnx", 64'({wny, wnx}), 64'd0);
    chk("rst_dy", 64'(dy), 64'd0);
    chk("rst_dx", 64'(dx), 64'd0);
    chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
    chk("rst_iss_ready", 64'(iss_ready), 64'd1);
    m_rr = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    cur = '{default: '0};
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Port monitor: compares registered outputs shortly after each rising edge.
  initial forever begin
    port_t e;
    @(posedge clk);
    #2;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wey", 64'(wey), 64'(e.wey));
      chk("wex", 64'(wex), 64'(e.wex));
      chk("wny", 64'(wny), 64'(e.wny));
      chk("wnx", 64'(wnx), 64'(e.wnx));
      chk("dy", 64'(dy), 64'(e.dy));
      chk("dx", 64'(dx), 64'(e.dx));
      if (wey && wex) chk("port_collision", 64'(wny == wnx), 64'd0);
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      s_vld[i] = 1'b0;
      s_rd[i]  = '0;
      s_dat[i] = '0;
    end
    #1;
    reset_pulse();

    // Reset then idle
    repeat (10) cycle();

    // Dual grant from rr=0, rd 1..4
    for (int i = 0; i < 4; i++) begin
      s_vld[i] = 1'b1;
      s_rd[i]  = AW'(i + 1);
      s_dat[i] = 32'hA000_0000 + 32'(i);
    end
    cycle();
    cycle();
    cycle();

    // Single writeback of r5 through fadd
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    cycle();
    rs_a = 5'd5;
    cycle();
    s_vld[1] = 1'b1;
    s_rd[1]  = 5'd5;
    s_dat[1] = 32'h3F80_0000;
    repeat (3) cycle();

    // Same-rd guard: fmul and fdiv both target r7, rr=2
    s_vld[2] = 1'b1; s_rd[2] = 5'd7; s_dat[2] = 32'h1111_2222;
    s_vld[3] = 1'b1; s_rd[3] = 5'd7; s_dat[3] = 32'h3333_4444;
    repeat (3) cycle();

    // WAW stall on r9
    rs_b      = 5'd9;
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    cycle();
    iss_valid = 1'b1;
    repeat (3) cycle();
    s_vld[0] = 1'b1; s_rd[0] = 5'd9; s_dat[0] = 32'h4049_0FDB;
    repeat (5) cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!s_vld[i] && $urandom_range(0, 1) == 1) begin
          s_vld[i] = 1'b1;
          s_rd[i]  = AW'($urandom_range(0, 7));
          s_dat[i] = 32'($urandom);
        end
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = AW'($urandom_range(0, 7));
      rs_a      = AW'($urandom_range(0, 7));
      rs_b      = AW'($urandom_range(0, 7));
      cycle();
    end
    for (int i = 0; i < 4; i++) s_vld[i] = 1'b0;
    iss_valid = 1'b0;
    repeat (3) cycle();

    // Async reset mid-stream: pending = 0x0F0F and both ports writing
    #2;
    reset_pulse();
    for (int r = 0; r < 8; r++) begin
      iss_valid = 1'b1;
      iss_rd    = AW'((r < 4) ? r : r + 4);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      s_vld[i] = 1'b1;
      s_rd[i]  = AW'(12 + i);
      s_dat[i] = 32'hC0DE_0000 + 32'(i);
    end
    rs_a = 5'd0;
    rs_b = 5'd11;
    cycle();
    #2;
    chk("pre_rst_both_ports", 64'({wey, wex}), 64'd3);
    reset_pulse();
    // fmul/fdiv still held; fadd re-presents. From source 0: fadd->y, fmul->x.
    s_vld[1] = 1'b1; s_rd[1] = 5'd16; s_dat[1] = 32'hBEEF_0001;
    repeat (4) cycle();

    @(posedge clk);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Schedules writebacks from four FP result sources onto the two write ports (x, y) of the FP register file: load, fadd, fmul, fdiv.
- Uses a round-robin valid/ready arbiter with registered port outputs.
- Contains a 32-entry pending-write scoreboard. Issue logic uses it to detect RAW hazards on two source registers and to stall WAW.
- Sits between the FP execution units and the FP register file. Issue stage drives the scoreboard side.

Parameters:
DW, 32, data width of one FP register
AW, 5, register address width (32 registers)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  4  per-source result valid; [0]=load, [1]=fadd, [2]=fmul, [3]=fdiv
req_rd  input  4*AW  per-source destination register; source i at [i*AW +: AW]
req_data  input  4*DW  per-source result; source i at [i*DW +: DW]
req_ready  output  4  per-source grant; a transfer occurs on valid&ready at posedge clk
wey  output  1  port-y write enable (regfile high-priority port)
wny  output  AW  port-y register number
dy  output  DW  port-y data
wex  output  1  port-x write enable
wnx  output  AW  port-x register number
dx  output  DW  port-x data
iss_valid  input  1  issue stage dispatching an FP op that writes iss_rd
iss_rd  input  AW  destination of the dispatched op
iss_ready  output  1  dispatch accepted (iss_valid&iss_ready marks iss_rd pending)
rs_a  input  AW  source register A lookup
rs_b  input  AW  source register B lookup
busy_a  output  1  pending[rs_a]
busy_b  output  1  pending[rs_b]

Behaviour:
- Reset (async, any time including mid-transfer):
  - wey=wex=0; wny=wnx=0; dy=dx=0.
  - rr pointer=0; pending=32'h0.
  - Combinational outputs follow from the cleared state: req_ready=0 when no valid; iss_ready=1 when pending=0; busy_a=busy_b=0.
  - No partial writes survive reset.
- Arbitration (combinational, each cycle):
  - Scan sources in order rr, rr+1, rr+2, rr+3 (mod 4).
  - First valid source wins slot Y.
  - Next valid source whose req_rd differs from slot-Y rd wins slot X.
  - A later source with the same rd as slot Y is not granted that cycle.
  - At most two grants per cycle. req_ready[i]=1 only for granted sources.
- Handshake:
  - A source must hold valid, rd and data stable until ready.
  - valid must not depend on ready.
  - Ungranted sources wait with no data loss.
- Output registers:
  - At posedge, slot Y loads wey/wny/dy and slot X loads wex/wnx/dx.
  - An empty slot loads we=0; wn/d hold their previous values.
  - Latency: handshake edge -> port valid for 1 cycle -> regfile written at the following edge.
  - The arbiter never drives wey&wex with wny==wnx, so the regfile's y-over-x priority never resolves a collision.
- rr update:
  - On any grant: rr <= (index of last granted source)+1 mod 4.
  - On no grant: rr holds.
- Scoreboard:
  - Set pending[iss_rd] on iss_valid&iss_ready.
  - Clear pending[wny] when wey=1 and pending[wnx] when wex=1, on the edge the regfile writes.
  - Set and clear in the same cycle on different registers both apply.
  - iss_ready = ~pending[iss_rd]. This is conservative: a register being cleared this cycle still reads as busy, so a set and a clear of the same bit in one cycle never occur.
  - Writebacks to non-pending registers are allowed; the clear is a no-op.
  - busy_a/busy_b are combinational reads of pending; there is no bypass from the write ports.
- Boundary cases:
  - All four sources valid: exactly two granted; the other two are granted no later than the next cycle.
  - No source starves beyond 2 cycles when every source is continuously valid.

Test Plan:
- Reset then idle:
  - Stimulus: release rst_n, req_valid=0, iss_valid=0.
  - Required: wey=wex=0, dy=dx=0, pending=0, iss_ready=1, busy_a=busy_b=0 for 10 cycles.
- Single writeback:
  - Stimulus: iss_rd=5 issued. Next cycle busy_a=1 with rs_a=5. Then fadd req_valid, rd=5, data=32'h3F800000.
  - Required: req_ready[1]=1 same cycle. Next cycle wey=1, wny=5, dy=32'h3F800000, wex=0. Following cycle busy_a=0.
- Dual grant, round-robin, rr=0:
  - Stimulus: all four valid, rd=1,2,3,4.
  - Required: cycle 1 grants load->Y, fadd->X; cycle 2 grants fmul->Y, fdiv->X. rr returns to 0.
- Same-rd guard:
  - Stimulus: fmul and fdiv both valid with rd=7, rr=2.
  - Required: only fmul granted (wey=1, wny=7, wex=0). fdiv granted the next cycle on Y.
- WAW stall:
  - Stimulus: iss_rd=9 while pending[9]=1.
  - Required: iss_ready=0 until the cycle after wny=9 or wnx=9 is written. Then iss_ready=1 and pending[9] is set again.
- Async reset mid-stream:
  - Stimulus: assert rst_n low while wex=wey=1 and pending=32'h0000_0F0F.
  - Required: outputs zero immediately, pending=0, rr=0. Held requests are re-arbitrated from source 0 after release.
